mcpu_core_fetch_queue: RTL and testbench
========================================

# mcpu_core_fetch_queue

Parametrised fetch stage with a packet queue between the I$ and decode. It takes translated fetch addresses from the fetch TLB and issues them to the I$. Returned packets and their virtual PCs go into a DEPTH-entry FIFO, and decode drains that FIFO with its own valid/ready handshake. Decode can therefore stall without blocking I$ hits, and a pipeline flush discards everything in flight.

## Interface
Parameters:
- PKT_W, 128, instruction packet width
- VPC_W, 28, virtual PC width (packet-granular)
- PPAGE_W, 20, physical page number width
- OFS_W, 8, in-page PC offset bits; f2ic_paddr width is PPAGE_W+OFS_W
- DEPTH, 4, queue entries; power of two, 2..16
- CNT_W, $clog2(DEPTH)+1, occupancy width

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clkrst_core_clk  in  1  core clock; all state updates on its rising edge
  - clkrst_core_rst_n  in  1  asynchronous, active-low reset
- f_valid  in  1  TLB result present, request wants to fetch
- ft2f_in_physpage  in  PPAGE_W  translated page
- ft2f_in_virtpc  in  VPC_W  virtual PC of request
- f2ft_accept  out  1  request consumed this cycle; TLB may advance
- f2ic_valid  out  1  I$ request
- f2ic_paddr  out  PPAGE_W+OFS_W  {ft2f_in_physpage, ft2f_in_virtpc[OFS_W-1:0]}
- ic2f_packet  in  PKT_W  I$ data, valid when f2ic_valid & ic2f_ready
- ic2f_ready  in  1  I$ hit / data returned this cycle
- f2d_valid  out  1  queue head valid
- f2d_out_packet  out  PKT_W  head packet
- f2d_out_virtpc  out  VPC_W  head virtual PC
- d2f_ready  in  1  decode takes head this cycle
- f2d_count  out  CNT_W  current occupancy
- pipe_flush  in  1  discard queue and in-flight request

## Operation
- Storage: DEPTH entries of {packet, virtpc}, write pointer, read pointer, occupancy counter; pointers are $clog2(DEPTH) bits and wrap naturally.
- not_full = (count < DEPTH). There is no bypass: a full queue refuses requests even when a pop occurs in the same cycle, so there is no combinational path from d2f_ready to f2ic_valid.
- f2ic_valid = f_valid & not_full & ~pipe_flush.
- f2ic_paddr is combinational from its inputs at all times.
- push = f2ic_valid & ic2f_ready.
  - Write {ic2f_packet, ft2f_in_virtpc} at wptr; wptr++.
  - f2ft_accept = push.
- f2d_valid = (count != 0) & ~pipe_flush.
  - f2d_out_packet and f2d_out_virtpc come from the entry at rptr, combinationally.
- pop = f2d_valid & d2f_ready; rptr++.
- Occupancy update:
  - count += push − pop;
  - simultaneous push and pop leaves count unchanged;
  - f2d_count = count.
- Flush (synchronous): while pipe_flush = 1, push and pop are both suppressed. On that edge count, wptr and rptr clear to 0; storage contents are left unchanged.
- If the I$ misses (ic2f_ready = 0), the request is held; the TLB keeps its inputs stable until f2ft_accept.

## Timing
- Reset (asynchronous assert, synchronous deassert by the system):
  - count, wptr, rptr and all storage are 0;
  - f2d_valid = 0, f2d_count = 0, f2ft_accept = 0;
  - f2d_out_packet = 0, f2d_out_virtpc = 0;
  - f2ic_valid follows f_valid, which is 0 during reset.
- Latency: a packet pushed at edge N appears with f2d_valid = 1 in the cycle after edge N. Minimum I$-to-decode latency is 1 cycle.
- Throughput: one push and one pop per cycle, sustained, while 0 < count < DEPTH.
- Full (count = DEPTH): f2ic_valid = 0. It reasserts in the cycle after the first pop.
- Empty: f2d_valid = 0; d2f_ready is ignored.
- Wrap: after DEPTH pushes, wptr returns to 0. FIFO order is preserved across the wrap.
- Reset or flush mid-operation: any entries in flight are lost and never presented to decode.

## Test plan
- Reset: hold rst_n = 0, f_valid = 1 → f2d_valid = 0, f2d_count = 0. After release with ic2f_ready = 1, virtpc 0x0000010 and physpage 0x12345 → f2ic_paddr = 0x1234510, and f2d_valid rises 1 cycle later with virtpc 0x0000010.
- Fill (DEPTH = 4): d2f_ready = 0, push 4 packets P0..P3 → f2d_count = 4 and f2ic_valid = 0 with f_valid = 1. Then assert d2f_ready one cycle → P0 popped; f2ic_valid = 1 on the next cycle.
- Streaming: ic2f_ready = 1 and d2f_ready = 1 for 10 cycles → f2d_count stays at 1, decode sees 10 packets in order, and pointers wrap twice without loss.
- I$ miss: ic2f_ready = 0 for 3 cycles → f2ft_accept = 0 and count is unchanged. Then ic2f_ready = 1 → exactly one push, carrying the held virtpc.
- Flush with count = 3, f_valid = 1 and ic2f_ready = 1 → no push and no pop that cycle; next cycle f2d_count = 0 and f2d_valid = 0. The first packet after the flush lands at entry 0 and is delivered intact.
- Asynchronous reset asserted mid-stream with count = 2 → f2d_valid and f2d_count drop to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mcpu_core_fetch_queue.sv
// ---------------------------------------------------------------------------
// mcpu_core_fetch_queue
//
// Fetch stage with a packet queue between the I$ and decode. Translated fetch
// requests from the fetch TLB are issued to the I$; returned packets and their
// virtual PCs are queued in a DEPTH-entry FIFO that decode drains with its own
// valid/ready handshake, so a decode stall does not block I$ hits. A pipeline
// flush discards the queue and any in-flight request.
//
// Ports:
//   clkrst_core_clk    in   core clock, rising-edge
//   clkrst_core_rst_n  in   asynchronous active-low reset
//   f_valid            in   TLB result present, request wants to fetch
//   ft2f_in_physpage   in   translated physical page
//   ft2f_in_virtpc     in   virtual PC of the request (packet-granular)
//   f2ft_accept        out  request consumed this cycle, TLB may advance
//   f2ic_valid         out  I$ request valid
//   f2ic_paddr         out  {physpage, virtpc[OFS_W-1:0]}
//   ic2f_packet        in   I$ data, valid when f2ic_valid & ic2f_ready
//   ic2f_ready         in   I$ hit / data returned this cycle
//   f2d_valid          out  queue head valid
//   f2d_out_packet     out  head packet
//   f2d_out_virtpc     out  head virtual PC
//   d2f_ready          in   decode takes the head this cycle
//   f2d_count          out  current occupancy
//   pipe_flush         in   discard queue and in-flight request
// ---------------------------------------------------------------------------
module mcpu_core_fetch_queue #(
    parameter int PKT_W   = 128,
    parameter int VPC_W   = 28,
    parameter int PPAGE_W = 20,
    parameter int OFS_W   = 8,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic                     clkrst_core_clk,
    input  logic                     clkrst_core_rst_n,
    input  logic                     f_valid,
    input  logic [PPAGE_W-1:0]       ft2f_in_physpage,
    input  logic [VPC_W-1:0]         ft2f_in_virtpc,
    output logic                     f2ft_accept,
    output logic                     f2ic_valid,
    output logic [PPAGE_W+OFS_W-1:0] f2ic_paddr,
    input  logic [PKT_W-1:0]         ic2f_packet,
    input  logic                     ic2f_ready,
    output logic                     f2d_valid,
    output logic [PKT_W-1:0]         f2d_out_packet,
    output logic [VPC_W-1:0]         f2d_out_virtpc,
    input  logic                     d2f_ready,
    output logic [CNT_W-1:0]         f2d_count,
    input  logic                     pipe_flush
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [PKT_W-1:0] r_pkt [DEPTH];
    logic [VPC_W-1:0] r_vpc [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic w_not_full;
    logic w_push;
    logic w_pop;

    // Fullness looks only at the registered count, never at d2f_ready, so
    // there is no combinational path from decode back to the I$ request.
    assign w_not_full  = (r_count < DEPTH_C);
    assign f2ic_valid  = f_valid & w_not_full & ~pipe_flush;
    assign f2ic_paddr  = {ft2f_in_physpage, ft2f_in_virtpc[OFS_W-1:0]};
    assign w_push      = f2ic_valid & ic2f_ready;
    assign f2ft_accept = w_push;

    assign f2d_valid      = (r_count != '0) & ~pipe_flush;
    assign f2d_out_packet = r_pkt[r_rptr];
    assign f2d_out_virtpc = r_vpc[r_rptr];
    assign w_pop          = f2d_valid & d2f_ready;
    assign f2d_count      = r_count;

    // Storage: cleared only by reset; a flush leaves contents in place.
    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_pkt[i] <= '0;
                r_vpc[i] <= '0;
            end
        end else if (w_push) begin
            r_pkt[r_wptr] <= ic2f_packet;
            r_vpc[r_wptr] <= ft2f_in_virtpc;
        end
    end

    // Pointers and occupancy. push/pop are already gated off during a flush.
    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (pipe_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_mcpu_core_fetch_queue.sv
module tb_mcpu_core_fetch_queue;

    localparam int PKT_W   = 128;
    localparam int VPC_W   = 28;
    localparam int PPAGE_W = 20;
    localparam int OFS_W   = 8;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 3;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     f_valid;
    logic [PPAGE_W-1:0]       page;
    logic [VPC_W-1:0]         vpc;
    logic                     accept;
    logic                     ic_valid;
    logic [PPAGE_W+OFS_W-1:0] paddr;
    logic [PKT_W-1:0]         ic_pkt;
    logic                     ic_ready;
    logic                     d_valid;
    logic [PKT_W-1:0]         d_pkt;
    logic [VPC_W-1:0]         d_vpc;
    logic                     d_ready;
    logic [CNT_W-1:0]         count;
    logic                     flush;

    always #5 clk = ~clk;

    mcpu_core_fetch_queue #(
        .PKT_W(PKT_W), .VPC_W(VPC_W), .PPAGE_W(PPAGE_W),
        .OFS_W(OFS_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clkrst_core_clk  (clk),
        .clkrst_core_rst_n(rst_n),
        .f_valid          (f_valid),
        .ft2f_in_physpage (page),
        .ft2f_in_virtpc   (vpc),
        .f2ft_accept      (accept),
        .f2ic_valid       (ic_valid),
        .f2ic_paddr       (paddr),
        .ic2f_packet      (ic_pkt),
        .ic2f_ready       (ic_ready),
        .f2d_valid        (d_valid),
        .f2d_out_packet   (d_pkt),
        .f2d_out_virtpc   (d_vpc),
        .d2f_ready        (d_ready),
        .f2d_count        (count),
        .pipe_flush       (flush)
    );

    typedef struct {
        logic [PKT_W-1:0] pkt;
        logic [VPC_W-1:0] vpc;
    } entry_t;

    typedef struct {
        logic        fv;
        logic        icr;
        logic        dr;
        logic        fl;
        int unsigned cnt;   // expected f2d_count before the edge
        logic        icv;   // expected f2ic_valid before the edge
    } vec_t;

    entry_t      sb[$];
    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned pops  = 0;
    int unsigned pushes = 0;

    task automatic chk(input string name, input logic [PKT_W-1:0] act, input logic [PKT_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called with inputs already driven (one time unit after an edge). Checks
    // every output against the scoreboard, clocks once, updates the model.
    task automatic cycle();
        int unsigned m_cnt;
        logic e_icv, e_push, e_dv, e_pop;
        #1;
        m_cnt  = sb.size();
        e_icv  = f_valid & (m_cnt < DEPTH) & ~flush;
        e_push = e_icv & ic_ready;
        e_dv   = (m_cnt != 0) & ~flush;
        e_pop  = e_dv & d_ready;
        chk("f2ic_valid", PKT_W'(ic_valid), PKT_W'(e_icv));
        chk("f2ft_accept", PKT_W'(accept), PKT_W'(e_push));
        chk("f2d_valid", PKT_W'(d_valid), PKT_W'(e_dv));
        chk("f2d_count", PKT_W'(count), PKT_W'(m_cnt));
        chk("f2ic_paddr", PKT_W'(paddr), PKT_W'({page, vpc[OFS_W-1:0]}));
        if (e_dv) begin
            chk("head_packet", d_pkt, sb[0].pkt);
            chk("head_virtpc", PKT_W'(d_vpc), PKT_W'(sb[0].vpc));
        end
        @(posedge clk);
        if (flush) begin
            sb.delete();
        end else begin
            if (e_pop) begin
                void'(sb.pop_front());
                pops++;
            end
            if (e_push) begin
                sb.push_back('{pkt: ic_pkt, vpc: vpc});
                pushes++;
            end
        end
        #1;
        // TLB holds its request until accepted; packet data changes freely.
        if (e_push) begin
            vpc  = vpc + VPC_W'(1);
            page = PPAGE_W'($urandom);
        end
        ic_pkt = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic drive(input logic fv, input logic icr, input logic dr, input logic fl);
        f_valid  = fv;
        ic_ready = icr;
        d_ready  = dr;
        flush    = fl;
    endtask

    vec_t tbl[14];
    int unsigned p0, n0;

    initial begin
        tbl[0]  = '{1, 1, 0, 0, 0, 1};
        tbl[1]  = '{1, 1, 0, 0, 1, 1};
        tbl[2]  = '{1, 1, 0, 0, 2, 1};
        tbl[3]  = '{1, 1, 0, 0, 3, 1};
        tbl[4]  = '{1, 1, 0, 0, 4, 0};   // full: request refused
        tbl[5]  = '{1, 1, 1, 0, 4, 0};   // pop while full: still no push
        tbl[6]  = '{1, 1, 0, 0, 3, 1};   // reasserts the cycle after the pop
        tbl[7]  = '{1, 0, 0, 0, 4, 0};
        tbl[8]  = '{1, 1, 1, 1, 4, 0};   // flush while full
        tbl[9]  = '{0, 1, 1, 0, 0, 0};
        tbl[10] = '{1, 0, 1, 0, 0, 1};   // miss
        tbl[11] = '{1, 1, 1, 0, 0, 1};   // first push after flush
        tbl[12] = '{0, 0, 1, 0, 1, 0};   // delivered and popped
        tbl[13] = '{0, 0, 0, 0, 0, 0};

        // Reset with f_valid high: queue outputs all zero.
        rst_n = 1'b0;
        drive(1, 0, 1, 0);
        vpc = '0; page = '0; ic_pkt = '0;
        #12;
        chk("rst_f2d_valid", PKT_W'(d_valid), '0);
        chk("rst_f2d_count", PKT_W'(count), '0);
        chk("rst_packet", d_pkt, '0);
        chk("rst_virtpc", PKT_W'(d_vpc), '0);
        chk("rst_accept", PKT_W'(accept), '0);
        chk("rst_f2ic_valid", PKT_W'(ic_valid), PKT_W'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // First request after reset, then it shows up one cycle later.
        vpc  = 28'h0000010;
        page = 20'h12345;
        ic_pkt = {4{32'hCAFE0000}};
        drive(1, 1, 0, 0);
        #1;
        chk("paddr_example", PKT_W'(paddr), PKT_W'(28'h1234510));
        cycle();
        drive(0, 0, 0, 0);
        #1;
        chk("latency_valid", PKT_W'(d_valid), PKT_W'(1));
        chk("latency_virtpc", PKT_W'(d_vpc), PKT_W'(28'h0000010));
        drive(0, 0, 1, 0);
        cycle();
        drive(0, 0, 0, 0);
        cycle();

        // Table: fill, full, no-bypass pop, flush, miss, restart.
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].fv, tbl[i].icr, tbl[i].dr, tbl[i].fl);
            #1;
            chk($sformatf("tbl%0d_count", i), PKT_W'(count), PKT_W'(tbl[i].cnt));
            chk($sformatf("tbl%0d_icv", i), PKT_W'(ic_valid), PKT_W'(tbl[i].icv));
            cycle();
        end

        // Streaming: prime one entry, then 10 cycles of push+pop.
        drive(1, 1, 0, 0);
        cycle();
        p0 = pops;
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 1, 0);
            cycle();
        end
        chk("stream_pops", PKT_W'(pops - p0), PKT_W'(10));

        // I$ miss for 3 cycles holds the request, then exactly one push.
        n0 = pushes;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0);
            cycle();
        end
        chk("miss_no_push", PKT_W'(pushes - n0), '0);
        drive(1, 1, 0, 0);
        cycle();
        chk("miss_one_push", PKT_W'(pushes - n0), PKT_W'(1));
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0);
            cycle();
        end

        // Flush with count = 3 and a live request.
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0);
            cycle();
        end
        n0 = pushes;
        drive(1, 1, 1, 1);
        cycle();
        chk("flush_no_push", PKT_W'(pushes - n0), '0);
        drive(0, 0, 0, 0);
        #1;
        chk("flush_count", PKT_W'(count), '0);
        chk("flush_valid", PKT_W'(d_valid), '0);
        drive(1, 1, 0, 0);
        cycle();
        drive(0, 0, 1, 0);
        cycle();

        // Asynchronous reset mid-stream with count = 2.
        drive(1, 1, 0, 0);
        cycle();
        cycle();
        drive(0, 0, 0, 0);
        #2;
        chk("pre_areset_count", PKT_W'(count), PKT_W'(2));
        rst_n = 1'b0;
        #1;
        chk("areset_valid", PKT_W'(d_valid), '0);
        chk("areset_count", PKT_W'(count), '0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(0, 0, 1, 0);
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
